separable_switch_allocator: RTL and testbench
=============================================

// Module: separable_switch_allocator
// PURPOSE
// - Input-first separable switch allocator: consumer of the input block's per-VC output-port requests.
// - Stage 1: per input port, a round-robin arbiter picks one eligible VC.
// - Stage 2: per output port, a round-robin arbiter picks one input among the stage-1 winners.
// - Results are registered:
//   - per-input VC select, returned to the input block for switch traversal;
//   - per-output crossbar select, sent to the crossbar.
// PARAMETERS
// - VC_NUM     2                     virtual channels per input port
// - PORT_NUM   5                     router ports (port_t encoding: LOCAL=0, NORTH, SOUTH, WEST, EAST=4)
// - VC_SIZE    $clog2(VC_NUM)        VC index width
// - PORT_SIZE  $clog2(PORT_NUM)      port index width
// PORTS
// - clk          in   1                          router clock
// - rst          in   1                          synchronous, active-low reset
// - out_port     in   port_t [PORT_NUM][VC_NUM]  requested output port per input VC
// - req_valid    in   [PORT_NUM][VC_NUM]         input VC holds a flit and has a downstream VC allocated
// - down_vc      in   [PORT_NUM][VC_NUM][VC_SIZE]  allocated downstream VC per input VC
// - credit_ok    in   [PORT_NUM][VC_NUM]         output port o, downstream VC d has >=1 credit
// - vc_sel       out  [PORT_NUM][VC_SIZE]        granted VC index per input port
// - valid_sel    out  [PORT_NUM]                 input port i granted this cycle
// - xb_sel       out  [PORT_NUM][PORT_SIZE]      input port driving output o
// - xb_valid     out  [PORT_NUM]                 output o carries a flit this cycle
// BEHAVIOUR
// - Reset (rst==0 at posedge clk): vc_sel, valid_sel, xb_sel and xb_valid all 0.
//   - All input pointers in_ptr[i] and output pointers out_ptr[o] are cleared to 0.
//   - Reset asserted mid-operation discards any pending grant. The cycle after reset, all outputs are 0.
// - Eligibility: input VC (i,v) is eligible iff all of the following hold:
//   - req_valid[i][v]==1;
//   - out_port[i][v] < PORT_NUM (out-of-range values are ignored, never granted);
//   - credit_ok[out_port[i][v]][down_vc[i][v]]==1.
// - Stage 1: w_i = first eligible v scanning in_ptr[i], in_ptr[i]+1, ... (mod VC_NUM).
//   - Input i requests output out_port[i][w_i]. If no eligible VC exists, input i makes no request.
// - Stage 2: g_o = first requesting input scanning out_ptr[o], out_ptr[o]+1, ... (mod PORT_NUM).
// - Stage 2 loser: an input that wins stage 1 but loses stage 2 gets no grant that cycle.
//   - No second-choice VC is tried within the same cycle.
// - Latency: one cycle. Requests sampled at edge t produce outputs valid from edge t+1 for exactly one cycle.
//   - Outputs are recomputed every cycle; no grant is held.
// - On grant of (i,w_i) to output o:
//   - valid_sel[i]=1, vc_sel[i]=w_i, xb_valid[o]=1, xb_sel[o]=i;
//   - in_ptr[i] <= (w_i+1) mod VC_NUM;
//   - out_ptr[o] <= (i+1) mod PORT_NUM.
// - Pointers of ungranted inputs/outputs hold. Stage-1 winners that lose stage 2 do NOT advance in_ptr.
// - Ungranted ports: valid_sel[i]=0 with vc_sel[i]=0; xb_valid[o]=0 with xb_sel[o]=0.
// - Matching: at most one grant per input and one grant per output per cycle.
//   - xb_sel values of valid outputs are pairwise distinct.
// - No credit bookkeeping here: credit_ok comes from the VC-state owner.
//   - It already reflects grants issued in the previous cycle.
// - The input block deasserts req_valid for a VC whose last flit was granted.
//   - The allocator keeps no memory of outstanding grants.
// - A U-turn request (out_port equals own port index) is treated as any other request.
// - Pointer wrap: VC_NUM-1 -> 0 and PORT_NUM-1 -> 0; no other modular arithmetic.
// TESTING
// - Reset: drive all req_valid=1 with rst=0 for 2 cycles -> all outputs 0. Release -> first grants appear 1 cycle later.
// - Single request (2,1) -> EAST, credit_ok=1 -> next cycle:
//   - valid_sel[2]=1, vc_sel[2]=1;
//   - xb_valid[4]=1, xb_sel[4]=2;
//   - in_ptr[2]=0, out_ptr[4]=3.
// - Output contention: inputs 0,1,3 all target NORTH continuously, pointers 0 -> NORTH grants inputs 0,1,3,0,... on successive cycles.
// - VC fairness: input 1 VCs 0 and 1 both eligible to different free outputs -> grants alternate VC0, VC1, VC0.
// - Credit block: credit_ok[EAST][0]=0 for (0,0)->EAST, with (0,1)->WEST eligible -> input 0 granted VC1 to WEST.
//   - Raise credit_ok -> VC0 granted next.
// - Full load: all 10 VCs eligible with a permutation of outputs -> 5 grants per cycle.
//   - Bench checks each cycle: xb_sel distinct, valid_sel/xb_valid popcounts equal.
//   - Bench checks vc_sel/xb_sel cross-consistency every cycle.
// - Mid-op reset: assert rst=0 during contention -> outputs 0 next cycle, pointers restart at 0.

Source files
------------

// File: rtl/separable_switch_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : separable_switch_allocator_if
//  Description : Request/grant bundle between the router input block, the
//                VC-state owner, the crossbar and the switch allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface separable_switch_allocator_if #(
  parameter int VC_NUM    = 2,
  parameter int PORT_NUM  = 5,
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
);
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                req_valid;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   down_vc;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                credit_ok;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel;
  logic [PORT_NUM-1:0]                            valid_sel;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_sel;
  logic [PORT_NUM-1:0]                            xb_valid;

  // Requester side: input block / VC-state owner view
  modport master (
    output out_port, req_valid, down_vc, credit_ok,
    input  vc_sel, valid_sel, xb_sel, xb_valid
  );

  // Allocator side
  modport slave (
    input  out_port, req_valid, down_vc, credit_ok,
    output vc_sel, valid_sel, xb_sel, xb_valid
  );
endinterface
`default_nettype wire

// File: rtl/separable_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : separable_switch_allocator
//  Description : Input-first separable switch allocator. Stage 1 picks one
//                eligible VC per input (round robin), stage 2 picks one
//                input per output among stage-1 winners (round robin).
//                Grants are registered: one cycle request-to-grant latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module separable_switch_allocator #(
  parameter int VC_NUM    = 2,
  parameter int PORT_NUM  = 5,
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  separable_switch_allocator_if.slave  sa
);

  logic [PORT_NUM-1:0][VC_NUM-1:0]    eligible;
  logic [PORT_NUM-1:0]                s1_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   s1_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] s1_port;

  logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_q, vc_sel_d;
  logic [PORT_NUM-1:0]                valid_sel_q, valid_sel_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_q, xb_sel_d;
  logic [PORT_NUM-1:0]                xb_valid_q, xb_valid_d;

  // An input VC is eligible when it requests an in-range port whose target downstream VC has credit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (sa.req_valid[i][v] && (int'(sa.out_port[i][v]) < PORT_NUM)) begin
          eligible[i][v] = sa.credit_ok[sa.out_port[i][v]][sa.down_vc[i][v]];
        end
      end
    end
  end

  // Stage 1: per input, first eligible VC at or after the input pointer
  always_comb begin
    int                 idx;
    logic [VC_SIZE-1:0] vidx;
    s1_valid = '0;
    s1_vc    = '0;
    s1_port  = '0;
    idx      = 0;
    vidx     = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(in_ptr_q[i]) + k;
        if (idx >= VC_NUM) idx = idx - VC_NUM;
        vidx = VC_SIZE'(idx);
        if (!s1_valid[i] && eligible[i][vidx]) begin
          s1_valid[i] = 1'b1;
          s1_vc[i]    = vidx;
          s1_port[i]  = sa.out_port[i][vidx];
        end
      end
    end
  end

  // Stage 2: per output, first requesting input at or after the output pointer; advance winners' pointers
  always_comb begin
    int                   idx;
    logic [PORT_SIZE-1:0] pidx;
    logic                 found;
    vc_sel_d    = '0;
    valid_sel_d = '0;
    xb_sel_d    = '0;
    xb_valid_d  = '0;
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    idx         = 0;
    pidx        = '0;
    found       = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      found = 1'b0;
      for (int k = 0; k < PORT_NUM; k++) begin
        idx = int'(out_ptr_q[o]) + k;
        if (idx >= PORT_NUM) idx = idx - PORT_NUM;
        pidx = PORT_SIZE'(idx);
        if (!found && s1_valid[pidx] && (s1_port[pidx] == PORT_SIZE'(o))) begin
          found             = 1'b1;
          xb_valid_d[o]     = 1'b1;
          xb_sel_d[o]       = pidx;
          valid_sel_d[pidx] = 1'b1;
          vc_sel_d[pidx]    = s1_vc[pidx];
          in_ptr_d[pidx]    = (s1_vc[pidx] == VC_SIZE'(VC_NUM - 1)) ? '0
                                                                     : s1_vc[pidx] + VC_SIZE'(1);
          out_ptr_d[o]      = (idx == PORT_NUM - 1) ? '0 : PORT_SIZE'(idx + 1);
        end
      end
    end
  end

  // Grant and pointer registers; reset clears pending grants and restarts arbitration
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ptr_q    <= '0;
      out_ptr_q   <= '0;
      vc_sel_q    <= '0;
      valid_sel_q <= '0;
      xb_sel_q    <= '0;
      xb_valid_q  <= '0;
    end else begin
      in_ptr_q    <= in_ptr_d;
      out_ptr_q   <= out_ptr_d;
      vc_sel_q    <= vc_sel_d;
      valid_sel_q <= valid_sel_d;
      xb_sel_q    <= xb_sel_d;
      xb_valid_q  <= xb_valid_d;
    end
  end

  assign sa.vc_sel    = vc_sel_q;
  assign sa.valid_sel = valid_sel_q;
  assign sa.xb_sel    = xb_sel_q;
  assign sa.xb_valid  = xb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_separable_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_separable_switch_allocator
//  Description : Self-checking bench for separable_switch_allocator with a
//                behavioural round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_separable_switch_allocator;

  localparam int VN = 2;
  localparam int PN = 5;

  logic clk;
  logic rst;

  separable_switch_allocator_if #(.VC_NUM(VN), .PORT_NUM(PN)) ifc ();

  separable_switch_allocator #(.VC_NUM(VN), .PORT_NUM(PN)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int m_in_ptr [PN];
  int m_out_ptr[PN];
  logic [PN-1:0]        e_valid_sel;
  logic [PN-1:0][0:0]   e_vc_sel;
  logic [PN-1:0]        e_xb_valid;
  logic [PN-1:0][2:0]   e_xb_sel;

  // Computes the grants the allocator should register at the coming edge
  task automatic model_clock();
    int want[PN];
    int win[PN];
    e_valid_sel = '0;
    e_vc_sel    = '0;
    e_xb_valid  = '0;
    e_xb_sel    = '0;
    if (!rst) begin
      for (int i = 0; i < PN; i++) begin
        m_in_ptr[i]  = 0;
        m_out_ptr[i] = 0;
      end
      return;
    end
    for (int i = 0; i < PN; i++) begin
      want[i] = -1;
      win[i]  = 0;
      for (int k = 0; k < VN; k++) begin
        int v;
        int op;
        v  = (m_in_ptr[i] + k) % VN;
        op = int'(ifc.out_port[i][v]);
        if (want[i] < 0 && ifc.req_valid[i][v] && op < PN && ifc.credit_ok[op][ifc.down_vc[i][v]]) begin
          want[i] = op;
          win[i]  = v;
        end
      end
    end
    for (int o = 0; o < PN; o++) begin
      for (int k = 0; k < PN; k++) begin
        int j;
        j = (m_out_ptr[o] + k) % PN;
        if (want[j] == o) begin
          e_xb_valid[o]  = 1'b1;
          e_xb_sel[o]    = 3'(j);
          e_valid_sel[j] = 1'b1;
          e_vc_sel[j]    = 1'(win[j]);
          m_in_ptr[j]    = (win[j] + 1) % VN;
          m_out_ptr[o]   = (j + 1) % PN;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.req_valid = '0;
    ifc.out_port  = '0;
    ifc.down_vc   = '0;
    ifc.credit_ok = '1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ifc.req_valid = '1;
    for (int i = 0; i < PN; i++)
      for (int v = 0; v < VN; v++) ifc.out_port[i][v] = 3'((i + 1) % PN);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if ({ifc.valid_sel, ifc.vc_sel, ifc.xb_valid, ifc.xb_sel} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got vs=%b vc=%b xv=%b xs=%h, want all zero",
                 c, ifc.valid_sel, ifc.vc_sel, ifc.xb_valid, ifc.xb_sel);
      end
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (ifc.valid_sel !== 5'h1f || ifc.xb_valid !== 5'h1f || ifc.valid_sel !== e_valid_sel ||
        ifc.xb_sel !== e_xb_sel || ifc.vc_sel !== e_vc_sel) begin
      n_bad++;
      $display("FAIL reset_release: got vs=%b xv=%b xs=%h vc=%b, want vs=11111 xv=11111 xs=%h vc=%b",
               ifc.valid_sel, ifc.xb_valid, ifc.xb_sel, ifc.vc_sel, e_xb_sel, e_vc_sel);
    end
  endtask

  task automatic test_single();
    clear_inputs();
    do_reset();
    ifc.req_valid[2][1] = 1'b1;
    ifc.out_port[2][1]  = 3'd4;
    tick();
    n_vec++;
    if (ifc.valid_sel !== 5'b00100 || ifc.vc_sel[2] !== 1'b1 || ifc.xb_valid !== 5'b10000 ||
        ifc.xb_sel[4] !== 3'd2) begin
      n_bad++;
      $display("FAIL single_req: got vs=%b vc2=%b xv=%b xs4=%0d, want vs=00100 vc2=1 xv=10000 xs4=2",
               ifc.valid_sel, ifc.vc_sel[2], ifc.xb_valid, ifc.xb_sel[4]);
    end
    ifc.req_valid = '0;
    tick();
    n_vec++;
    if (ifc.valid_sel !== 5'b0 || ifc.xb_valid !== 5'b0) begin
      n_bad++;
      $display("FAIL single_no_hold: got vs=%b xv=%b, want 0", ifc.valid_sel, ifc.xb_valid);
    end
  endtask

  task automatic test_contention();
    int exp_in[4] = '{0, 1, 3, 0};
    clear_inputs();
    do_reset();
    ifc.req_valid[0][0] = 1'b1; ifc.out_port[0][0] = 3'd1;
    ifc.req_valid[1][0] = 1'b1; ifc.out_port[1][0] = 3'd1;
    ifc.req_valid[3][0] = 1'b1; ifc.out_port[3][0] = 3'd1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (ifc.xb_valid !== 5'b00010 || ifc.xb_sel[1] !== 3'(exp_in[c]) ||
          ifc.valid_sel !== (5'b1 << exp_in[c]) || ifc.vc_sel !== e_vc_sel) begin
        n_bad++;
        $display("FAIL contention cyc%0d: got xv=%b xs1=%0d vs=%b, want xv=00010 xs1=%0d",
                 c, ifc.xb_valid, ifc.xb_sel[1], ifc.valid_sel, exp_in[c]);
      end
    end
  endtask

  task automatic test_vc_fairness();
    logic exp_vc[3] = '{1'b0, 1'b1, 1'b0};
    clear_inputs();
    do_reset();
    ifc.req_valid[1] = 2'b11;
    ifc.out_port[1][0] = 3'd2;
    ifc.out_port[1][1] = 3'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (ifc.valid_sel !== 5'b00010 || ifc.vc_sel[1] !== exp_vc[c] ||
          ifc.xb_valid !== e_xb_valid || ifc.xb_sel !== e_xb_sel) begin
        n_bad++;
        $display("FAIL vc_fairness cyc%0d: got vs=%b vc1=%b xv=%b, want vs=00010 vc1=%b xv=%b",
                 c, ifc.valid_sel, ifc.vc_sel[1], ifc.xb_valid, exp_vc[c], e_xb_valid);
      end
    end
  endtask

  task automatic test_credit_block();
    clear_inputs();
    do_reset();
    ifc.req_valid[0] = 2'b11;
    ifc.out_port[0][0] = 3'd4;
    ifc.out_port[0][1] = 3'd3;
    ifc.credit_ok[4][0] = 1'b0;
    tick();
    n_vec++;
    if (ifc.valid_sel !== 5'b00001 || ifc.vc_sel[0] !== 1'b1 || ifc.xb_valid !== 5'b01000 ||
        ifc.xb_sel[3] !== 3'd0) begin
      n_bad++;
      $display("FAIL credit_block: got vs=%b vc0=%b xv=%b xs3=%0d, want vs=00001 vc0=1 xv=01000 xs3=0",
               ifc.valid_sel, ifc.vc_sel[0], ifc.xb_valid, ifc.xb_sel[3]);
    end
    ifc.credit_ok[4][0] = 1'b1;
    tick();
    n_vec++;
    if (ifc.valid_sel !== 5'b00001 || ifc.vc_sel[0] !== 1'b0 || ifc.xb_valid !== 5'b10000 ||
        ifc.xb_sel[4] !== 3'd0) begin
      n_bad++;
      $display("FAIL credit_release: got vs=%b vc0=%b xv=%b xs4=%0d, want vs=00001 vc0=0 xv=10000 xs4=0",
               ifc.valid_sel, ifc.vc_sel[0], ifc.xb_valid, ifc.xb_sel[4]);
    end
  endtask

  task automatic test_full_load();
    clear_inputs();
    do_reset();
    ifc.req_valid = '1;
    for (int i = 0; i < PN; i++)
      for (int v = 0; v < VN; v++) ifc.out_port[i][v] = 3'((i + 2) % PN);
    for (int c = 0; c < 6; c++) begin
      int  dup;
      int  xinc;
      tick();
      dup  = 0;
      xinc = 0;
      for (int a = 0; a < PN; a++) begin
        for (int b = a + 1; b < PN; b++)
          if (ifc.xb_valid[a] && ifc.xb_valid[b] && ifc.xb_sel[a] == ifc.xb_sel[b]) dup++;
        if (ifc.xb_valid[a]) begin
          int s;
          s = int'(ifc.xb_sel[a]);
          if (s >= PN || !ifc.valid_sel[s] || int'(ifc.out_port[s][ifc.vc_sel[s]]) != a) xinc++;
        end
      end
      n_vec++;
      if (ifc.valid_sel !== 5'h1f || ifc.xb_valid !== 5'h1f || dup != 0 || xinc != 0 ||
          $countones(ifc.valid_sel) != $countones(ifc.xb_valid) ||
          ifc.vc_sel !== e_vc_sel || ifc.xb_sel !== e_xb_sel) begin
        n_bad++;
        $display("FAIL full_load cyc%0d: got vs=%b xv=%b xs=%h vc=%b dup=%0d xinc=%0d, want vs=11111 xv=11111 xs=%h vc=%b",
                 c, ifc.valid_sel, ifc.xb_valid, ifc.xb_sel, ifc.vc_sel, dup, xinc, e_xb_sel, e_vc_sel);
      end
    end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int dup;
      for (int i = 0; i < PN; i++)
        for (int v = 0; v < VN; v++) begin
          ifc.req_valid[i][v] = ($urandom_range(0, 3) != 0);
          ifc.out_port[i][v]  = 3'($urandom_range(0, 7) % ((($urandom_range(0, 7)) == 0) ? 8 : 5));
          ifc.down_vc[i][v]   = 1'($urandom_range(0, 1));
          ifc.credit_ok[i][v] = ($urandom_range(0, 4) != 0);
        end
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      tick();
      dup = 0;
      for (int a = 0; a < PN; a++)
        for (int b = a + 1; b < PN; b++)
          if (ifc.xb_valid[a] && ifc.xb_valid[b] && ifc.xb_sel[a] == ifc.xb_sel[b]) dup++;
      n_vec++;
      if (ifc.valid_sel !== e_valid_sel || ifc.vc_sel !== e_vc_sel || ifc.xb_valid !== e_xb_valid ||
          ifc.xb_sel !== e_xb_sel || dup != 0) begin
        n_bad++;
        $display("FAIL random cyc%0d: got vs=%b vc=%b xv=%b xs=%h dup=%0d, want vs=%b vc=%b xv=%b xs=%h",
                 c, ifc.valid_sel, ifc.vc_sel, ifc.xb_valid, ifc.xb_sel, dup,
                 e_valid_sel, e_vc_sel, e_xb_valid, e_xb_sel);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_midop_reset();
    clear_inputs();
    do_reset();
    ifc.req_valid[0][0] = 1'b1; ifc.out_port[0][0] = 3'd1;
    ifc.req_valid[1][0] = 1'b1; ifc.out_port[1][0] = 3'd1;
    ifc.req_valid[3][0] = 1'b1; ifc.out_port[3][0] = 3'd1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({ifc.valid_sel, ifc.vc_sel, ifc.xb_valid, ifc.xb_sel} !== '0) begin
      n_bad++;
      $display("FAIL midop_reset: got vs=%b xv=%b xs=%h, want all zero",
               ifc.valid_sel, ifc.xb_valid, ifc.xb_sel);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (ifc.xb_valid !== 5'b00010 || ifc.xb_sel[1] !== 3'd0 || ifc.valid_sel !== 5'b00001) begin
      n_bad++;
      $display("FAIL midop_restart: got xv=%b xs1=%0d vs=%b, want xv=00010 xs1=0 vs=00001",
               ifc.xb_valid, ifc.xb_sel[1], ifc.valid_sel);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < PN; i++) begin
      m_in_ptr[i]  = 0;
      m_out_ptr[i] = 0;
    end
    test_reset();
    test_single();
    test_contention();
    test_vc_fairness();
    test_credit_block();
    test_full_load();
    test_random();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
